histogram_accumulator: RTL and testbench
========================================

# histogram_accumulator

Builds the per-frame 256-bin luminance histogram that the histogram display path reads back. Increments one bin per valid 8-bit pixel. At frame end it optionally scans the bins for the median threshold, then swaps a ping-pong RAM pair so the display reads a stable, complete histogram. It also publishes the frame's peak bin count and total pixel count for display normalisation.

## Interface
- `COUNT_W`, 20: bin and total counter width; all counts saturate at 2^COUNT_W-1.
- `THRESH_DEFAULT`, 128: value of `oThreshPoint` after reset, for empty frames, and when the median scan is compiled out.
- `iClk` in 1: sole clock, rising edge.
- `iRST_N` in 1: asynchronous, active-low reset.
- `iValid` in 1: `iPixel` is valid this cycle.
- `iPixel` in 8: pixel luminance, which is the bin index.
- `iFrameEnd` in 1: single-cycle pulse closing the current frame.
- `iRdAddr` in 8: display-side bin address.
- `oHistoValue` out COUNT_W: display-bank count for `iRdAddr`.
- `oMaxValue` out COUNT_W: largest bin count of the last completed frame.
- `oTotal` out COUNT_W: pixel count of the last completed frame.
- `oThreshPoint` out 8: median bin of the last completed frame.
- `oReady` out 1: high while in ACCUM; pixels are accepted only then.
- `oFrameDone` out 1: one-cycle pulse on the bank swap.

## Operation
- Two 256×COUNT_W banks. `bank_sel` selects the display bank; the other bank accumulates.
- States are CLEAR, ACCUM, DRAIN, SCAN, SWAP.
- Reset:
  - State is CLEAR; `bank_sel`=0; `disp_valid`=0.
  - `oMaxValue`, `oTotal`, `oFrameDone`, `oReady` are 0; `oThreshPoint`=THRESH_DEFAULT.
  - RAM contents are not reset.
- CLEAR:
  - Writes 0 to accumulate-bank addresses 0..255, one per cycle (256 cycles).
  - Zeroes the running max and running total.
  - Next state is ACCUM.
  - `iValid` and `iFrameEnd` are ignored.
- ACCUM:
  - A 3-stage read-modify-write: address on S0, data on S1, write of count+1 (saturating) on S2.
  - S2 to S1 forwarding is mandatory: back-to-back or one-apart pixels of equal value must each count.
  - Running max tracks the post-increment value. Running total increments with saturation.
  - `iFrameEnd` moves the block to DRAIN. A pixel valid in the same cycle is counted.
- DRAIN: 2 cycles for in-flight writes to retire.
- SCAN (only with the macro):
  - Reads accumulate-bank bins 0..255 and keeps a cumulative sum, with `half` = (total+1)>>1.
  - The threshold is the first bin whose cumulative sum is ≥ `half`.
  - If total = 0, the threshold is THRESH_DEFAULT.
  - Takes 258 cycles (256 reads plus 2-cycle RAM/sum latency).
- SWAP, one cycle:
  - Toggles `bank_sel` and sets `disp_valid`=1.
  - Latches `oMaxValue`, `oTotal`, `oThreshPoint`, and pulses `oFrameDone`.
  - Next state is CLEAR.
- Display read:
  - `oHistoValue` is registered from display bank[`iRdAddr`].
  - It reads 0 while `disp_valid`=0, i.e. before the first swap after reset.
- Reset asserted in any state aborts it immediately. The partial frame is discarded and no `oFrameDone` pulse is produced.

## Timing
- `oHistoValue` latency: 1 cycle after `iRdAddr`. It is unaffected by accumulation, clear, or scan activity.
- After reset release, `oReady` rises on cycle 256.
- `iFrameEnd` sampled at edge N gives `oFrameDone` high at:
  - with the macro: N+261 (2 drain + 258 scan + 1 swap);
  - without the macro: N+3.
- `oMaxValue`, `oTotal`, and `oThreshPoint` change only on the `oFrameDone` cycle.
- After `oFrameDone`, `oReady` is low for the 256 clear cycles, and pixels in that window are dropped.

## Configuration
- `HISTO_THRESH_EN` defined:
  - SCAN state and median logic are built.
  - `oThreshPoint` follows the median.
- Undefined:
  - DRAIN goes directly to SWAP.
  - No scan logic is built.
  - `oThreshPoint` stays at THRESH_DEFAULT permanently.

## Test plan
- Reset, then wait:
  - `oReady` rises exactly at cycle 256.
  - `oHistoValue`=0 for all addresses.
  - `oThreshPoint`=128, `oMaxValue`=0.
- 10 back-to-back pixels of value 7, then `iFrameEnd`:
  - Bin 7 reads 10; all other bins read 0.
  - `oMaxValue`=10, `oTotal`=10, `oThreshPoint`=7 (with the macro).
- Sequence 3,3,5,3 with no gaps, then 3,_,3:
  - Bin 3 reads 5 and bin 5 reads 1, proving forwarding.
- `COUNT_W`=4, 20 pixels of value 0:
  - Bin 0 reads 15, `oTotal`=15, `oMaxValue`=15.
- 10× value 0 plus 30× value 200: `oThreshPoint`=200.
  - A following empty frame gives `oThreshPoint`=128, `oMaxValue`=0, `oTotal`=0, and all bins read 0.
- Reset asserted mid-SCAN:
  - All outputs return to reset values and `oHistoValue` reads 0.
  - No `oFrameDone` pulse; the next frame accumulates correctly.

Source files
------------

// File: rtl/histogram_accumulator.sv
// histogram_accumulator: per-frame 256-bin luminance histogram in ping-pong banks.
// Define HISTO_THRESH_EN to build the frame-end median threshold scan.
module histogram_accumulator #(
    parameter int         COUNT_W        = 20,
    parameter logic [7:0] THRESH_DEFAULT = 8'd128
) (
    input  logic               iClk,
    input  logic               iRST_N,
    input  logic               iValid,
    input  logic [7:0]         iPixel,
    input  logic               iFrameEnd,
    input  logic [7:0]         iRdAddr,
    output logic [COUNT_W-1:0] oHistoValue,
    output logic [COUNT_W-1:0] oMaxValue,
    output logic [COUNT_W-1:0] oTotal,
    output logic [7:0]         oThreshPoint,
    output logic               oReady,
    output logic               oFrameDone
);
    typedef enum logic [2:0] {CLEAR, ACCUM, DRAIN, SCAN, SWAP} state_t;
    localparam logic [COUNT_W-1:0] CMAX = '1;

    state_t state, state_n;
    logic [COUNT_W-1:0] mem [2][256];
    logic [8:0] cnt;
    logic bank_sel, disp_valid;
    logic s1_v, s2_v, accept;
    logic [7:0] s1_a, s2_a;
    logic [COUNT_W-1:0] s1_d, s2_d, fwd, inc, run_max, run_total;

    assign accept = state == ACCUM && iValid;
    assign oReady = state == ACCUM;
    // The write retiring from S2 is newer than the RAM copy read a cycle earlier.
    assign fwd = (s2_v && s2_a == s1_a) ? s2_d : s1_d;
    assign inc = fwd == CMAX ? fwd : fwd + COUNT_W'(1);

`ifdef HISTO_THRESH_EN
    logic sc_v, found;
    logic [7:0] sc_i, thr;
    logic [COUNT_W-1:0] sc_d;
    logic [COUNT_W:0] half;
    logic [COUNT_W+8:0] cum, cum_n;
    logic [7:0] thr_out;
    assign half = ({1'b0, run_total} + (COUNT_W+1)'(1)) >> 1;
    assign cum_n = cum + {9'd0, sc_d};
    assign thr_out = (run_total == '0 || !found) ? THRESH_DEFAULT : thr;
    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N) begin
            sc_v  <= 1'b0;
            sc_i  <= '0;
            sc_d  <= '0;
            cum   <= '0;
            found <= 1'b0;
            thr   <= THRESH_DEFAULT;
        end else begin
            sc_v <= state == SCAN && cnt < 9'd256;
            sc_i <= cnt[7:0];
            sc_d <= mem[~bank_sel][cnt[7:0]];
            cum  <= state == DRAIN ? '0 : sc_v ? cum_n : cum;
            found <= state == DRAIN ? 1'b0 : (sc_v && cum_n >= {8'd0, half}) | found;
            thr  <= (sc_v && !found && cum_n >= {8'd0, half}) ? sc_i : thr;
        end
    end
`else
    logic [7:0] thr_out;
    assign thr_out = THRESH_DEFAULT;
`endif

    always_comb begin
        state_n = state;
        case (state)
            CLEAR: state_n = cnt == 9'd255 ? ACCUM : CLEAR;
            ACCUM: state_n = iFrameEnd ? DRAIN : ACCUM;
`ifdef HISTO_THRESH_EN
            DRAIN: state_n = cnt == 9'd1 ? SCAN : DRAIN;
            SCAN:  state_n = cnt == 9'd257 ? SWAP : SCAN;
`else
            DRAIN: state_n = cnt == 9'd1 ? SWAP : DRAIN;
`endif
            SWAP:  state_n = CLEAR;
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge iClk)
        if (state == CLEAR) mem[~bank_sel][cnt[7:0]] <= '0;
        else if (s2_v) mem[~bank_sel][s2_a] <= s2_d;

    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= CLEAR;
            cnt          <= '0;
            bank_sel     <= 1'b0;
            disp_valid   <= 1'b0;
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            s1_a         <= '0;
            s2_a         <= '0;
            s1_d         <= '0;
            s2_d         <= '0;
            run_max      <= '0;
            run_total    <= '0;
            oHistoValue  <= '0;
            oMaxValue    <= '0;
            oTotal       <= '0;
            oThreshPoint <= THRESH_DEFAULT;
            oFrameDone   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= state_n != state ? 9'd0 : cnt + 9'd1;
            s1_v        <= accept;
            s1_a        <= iPixel;
            s1_d        <= (s2_v && s2_a == iPixel) ? s2_d : mem[~bank_sel][iPixel];
            s2_v        <= s1_v;
            s2_a        <= s1_a;
            s2_d        <= inc;
            run_max     <= state == CLEAR ? '0 : (s1_v && inc > run_max) ? inc : run_max;
            run_total   <= state == CLEAR ? '0 : (accept && run_total != CMAX) ? run_total + COUNT_W'(1) : run_total;
            oHistoValue <= disp_valid ? mem[bank_sel][iRdAddr] : '0;
            oFrameDone  <= state == SWAP;
            if (state == SWAP) begin
                bank_sel     <= ~bank_sel;
                disp_valid   <= 1'b1;
                oMaxValue    <= run_max;
                oTotal       <= run_total;
                oThreshPoint <= thr_out;
            end
        end
    end
endmodule

// File: tb/tb_histogram_accumulator.sv
// tb_histogram_accumulator: table-driven, hand-written and random frames against a counting model.
// Runs a default-width DUT and a 4-bit DUT on the same stimulus.
module tb_histogram_accumulator;
    localparam int W = 20;
`ifdef HISTO_THRESH_EN
    localparam int LAT = 261;
    localparam bit THR_EN = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit THR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, fend = 1'b0;
    logic [7:0] pixel = '0, rd_addr = '0;
    logic [W-1:0] histo, maxv, total;
    logic [3:0] histo4, max4, total4;
    logic [7:0] thr, thr4;
    logic ready, ready4, done, done4;
    int tests = 0, fails = 0;
    int q[$];
    int exp_bins[2][256];
    int exp_max[2], exp_tot[2], exp_thr[2];
    int got[256], got4[256];

    typedef struct {
        string name;
        int a_val, a_n, b_val, b_n;
        int max_e, tot_e, thr_e, bin, bin_e;
    } vec_t;
    vec_t vt[4];

    always #5 clk = ~clk;

    histogram_accumulator #(.COUNT_W(W)) dut (
        .iClk(clk), .iRST_N(rst_n), .iValid(valid), .iPixel(pixel), .iFrameEnd(fend),
        .iRdAddr(rd_addr), .oHistoValue(histo), .oMaxValue(maxv), .oTotal(total),
        .oThreshPoint(thr), .oReady(ready), .oFrameDone(done));

    histogram_accumulator #(.COUNT_W(4)) dut4 (
        .iClk(clk), .iRST_N(rst_n), .iValid(valid), .iPixel(pixel), .iFrameEnd(fend),
        .iRdAddr(rd_addr), .oHistoValue(histo4), .oMaxValue(max4), .oTotal(total4),
        .oThreshPoint(thr4), .oReady(ready4), .oFrameDone(done4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Histogram of the accepted pixels, clipped to each DUT's counter ceiling.
    task automatic build_model();
        int cnt[256];
        foreach (cnt[i]) cnt[i] = 0;
        foreach (q[i]) cnt[q[i]]++;
        for (int k = 0; k < 2; k++) begin
            int cap, cum, half;
            bit found;
            cap = k ? 15 : (1 << W) - 1;
            cum = 0;
            found = 0;
            exp_max[k] = 0;
            exp_tot[k] = q.size() > cap ? cap : q.size();
            for (int b = 0; b < 256; b++) begin
                exp_bins[k][b] = cnt[b] > cap ? cap : cnt[b];
                if (exp_bins[k][b] > exp_max[k]) exp_max[k] = exp_bins[k][b];
            end
            half = (exp_tot[k] + 1) / 2;
            exp_thr[k] = 128;
            if (THR_EN && exp_tot[k] > 0)
                for (int b = 0; b < 256; b++) begin
                    cum += exp_bins[k][b];
                    if (!found && cum >= half) begin
                        found = 1;
                        exp_thr[k] = b;
                    end
                end
        end
    endtask

    task automatic readback(input bit drop);
        valid = drop;
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            pixel = 8'($urandom);
            @(posedge clk); #1;
            got[a] = int'(histo);
            got4[a] = int'(histo4);
        end
        valid = 1'b0;
    endtask

    task automatic check_bins(input string name);
        int bad, bad4;
        bad = 0;
        bad4 = 0;
        for (int a = 0; a < 256; a++) begin
            if (got[a] != exp_bins[0][a]) bad++;
            if (got4[a] != exp_bins[1][a]) bad4++;
        end
        check({name, " bins wrong"}, bad, 0);
        check({name, " bins4 wrong"}, bad4, 0);
    endtask

    task automatic send_pixels(input int seq[$], input bit end_with_last);
        q.delete();
        foreach (seq[i]) begin
            valid = seq[i] >= 0;
            pixel = seq[i] >= 0 ? 8'(seq[i]) : 8'($urandom);
            if (seq[i] >= 0) q.push_back(seq[i]);
            fend = end_with_last && i == seq.size() - 1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        if (!end_with_last) begin
            fend = 1'b1;
            @(posedge clk); #1;
        end
        fend = 1'b0;
    endtask

    task automatic close_frame(input string name);
        int k;
        bit held;
        logic [W-1:0] pm, pt;
        logic [7:0] pth;
        pm = maxv;
        pt = total;
        pth = thr;
        held = 1;
        k = 0;
        build_model();
        while (!done && k < LAT + 10) begin
            if (maxv !== pm || total !== pt || thr !== pth) held = 0;
            @(posedge clk); #1;
            k++;
        end
        check({name, " done latency"}, k, LAT);
        check({name, " outputs held"}, held, 1);
        check({name, " done4"}, done4, 1);
        check({name, " max"}, maxv, exp_max[0]);
        check({name, " total"}, total, exp_tot[0]);
        check({name, " thresh"}, thr, exp_thr[0]);
        check({name, " max4"}, max4, exp_max[1]);
        check({name, " total4"}, total4, exp_tot[1]);
        check({name, " thresh4"}, thr4, exp_thr[1]);
        readback(1'b1);
        check_bins(name);
        check({name, " ready after clear"}, ready, 1);
    endtask

    task automatic do_reset(input string name);
        int k;
        bit seen;
        seen = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        fend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (done) seen = 1;
        rst_n = 1'b1;
        k = 0;
        while (!ready && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (done) seen = 1;
        end
        check({name, " ready cycle"}, k, 256);
        check({name, " no done"}, seen, 0);
    endtask

    initial begin
        int s[$];
        vt[0] = '{"seven", 7, 10, 0, 0, 10, 10, 7, 7, 10};
        vt[1] = '{"split", 0, 10, 200, 30, 30, 40, 200, 200, 30};
        vt[2] = '{"empty", 0, 0, 0, 0, 0, 0, 128, 0, 0};
        vt[3] = '{"zeros20", 0, 20, 0, 0, 20, 20, 0, 0, 20};

        do_reset("reset");
        check("reset max", maxv, 0);
        check("reset total", total, 0);
        check("reset thresh", thr, 128);
        check("reset done", done, 0);
        q.delete();
        build_model();
        readback(1'b0);
        check_bins("reset");

        foreach (vt[i]) begin
            s.delete();
            for (int j = 0; j < vt[i].a_n; j++) s.push_back(vt[i].a_val);
            for (int j = 0; j < vt[i].b_n; j++) s.push_back(vt[i].b_val);
            send_pixels(s, 1'b0);
            close_frame(vt[i].name);
            check({vt[i].name, " tbl max"}, maxv, vt[i].max_e);
            check({vt[i].name, " tbl total"}, total, vt[i].tot_e);
            check({vt[i].name, " tbl thresh"}, thr, THR_EN ? vt[i].thr_e : 128);
            check({vt[i].name, " tbl bin"}, got[vt[i].bin], vt[i].bin_e);
        end

        s = {3, 3, 5, 3, 3, -1, 3};
        send_pixels(s, 1'b0);
        close_frame("fwd");
        check("fwd bin3", got[3], 5);
        check("fwd bin5", got[5], 1);

        s = {9, -1, -1, 9, 9, -1, 9};
        send_pixels(s, 1'b1);
        close_frame("fwd gap");
        check("fwd gap bin9", got[9], 4);

        s = {9, 9, 9};
        send_pixels(s, 1'b0);
        repeat (THR_EN ? 100 : 1) @(posedge clk);
        #1;
        check("abort no early done", done, 0);
        rst_n = 1'b0;
        #1;
        check("abort ready", ready, 0);
        check("abort max", maxv, 0);
        check("abort total", total, 0);
        check("abort thresh", thr, 128);
        check("abort histo", histo, 0);
        do_reset("abort");
        q.delete();
        build_model();
        readback(1'b0);
        check_bins("abort");

        for (int f = 0; f < 6; f++) begin
            int n;
            bit el;
            s.delete();
            n = $urandom_range(0, 60);
            for (int j = 0; j < n; j++)
                s.push_back($urandom_range(0, 3) == 0 ? -1 :
                            $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            el = n > 0 && $urandom_range(0, 1) == 1;
            if (el) s[n-1] = $urandom_range(0, 255);
            send_pixels(s, el);
            close_frame($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
